// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, datapath select codes,
// FSM states and the decoded instruction classes.
package cpu_ctrl_pkg;

    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StGetA,
        StGetB,
        StExec,
        StWbC,
        StWbImm,
        StHalt
    } state_t;

    typedef enum logic [2:0] {
        ClsIllegal,
        ClsMovImm,
        ClsMovReg,
        ClsAlu,
        ClsCmp,
        ClsMvn,
        ClsHalt
    } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: field extraction, immediates and instruction class.
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic [4:0]        imm5,
    output logic [DATA_W-1:0] sximm8,
    output instr_class_t      cls
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm5   = ir[4:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    always_comb begin
        cls = ClsIllegal;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM) begin
                    cls = ClsMovImm;
                end else if (op == OP_MOV_REG) begin
                    cls = ClsMovReg;
                end
            end
            OPC_ALU: begin
                case (op)
                    OP_CMP:  cls = ClsCmp;
                    OP_MVN:  cls = ClsMvn;
                    default: cls = ClsAlu;
                endcase
            end
            OPC_HALT: cls = ClsHalt;
            default:  cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: accepts one instruction per handshake and sequences the
// register/ALU datapath strobes until the instruction retires.
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        ins_in,
    input  logic               ins_valid,
    output logic               ins_ready,
    output logic [RADDR_W-1:0] readnum,
    output logic [RADDR_W-1:0] writenum,
    output logic               write,
    output logic [1:0]         vsel,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic [1:0]         ALUop,
    output logic [1:0]         shift,
    output logic [4:0]         imm5,
    output logic [DATA_W-1:0]  sximm8,
    input  logic [2:0]         status_in,
    output logic [2:0]         status_q,
    output logic               done,
    output logic               illegal,
    output logic               halted
);

    state_t       state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic [2:0]   status_d;
    logic [1:0]   op;
    logic [2:0]   rn, rd, rm;
    logic [1:0]   sh;
    instr_class_t cls;

    instr_decoder #(
        .DATA_W (DATA_W)
    ) u_instr_decoder (
        .ir     (ir_q),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .imm5   (imm5),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // IR only changes on an accepted handshake, so it is stable for the whole sequence.
    assign ir_d     = (state_q == StIdle && ins_valid) ? ins_in : ir_q;
    assign status_d = loads ? status_in : status_q;

    always_comb begin
        state_d   = state_q;
        ins_ready = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = ALU_ADD;
        shift     = 2'b00;
        done      = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            StIdle: begin
                ins_ready = 1'b1;
                if (ins_valid) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (cls)
                    ClsMovImm:         state_d = StWbImm;
                    ClsMovReg, ClsMvn: state_d = StGetB;
                    ClsAlu, ClsCmp:    state_d = StGetA;
                    ClsHalt:           state_d = StHalt;
                    default: begin
                        illegal = 1'b1;
                        state_d = StIdle;
                    end
                endcase
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                shift   = sh;
                loadb   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                // MOV reg and MVN have no A operand; force it to zero.
                asel  = (cls == ClsMovReg) || (cls == ClsMvn);
                ALUop = (cls == ClsMovReg) ? ALU_ADD : op;
                if (cls == ClsCmp) begin
                    loads   = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWbC;
                end
            end
            StWbC: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            StWbImm: begin
                vsel     = VSEL_IMM;
                writenum = rn;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller with hand-computed expected strobes.
module tb_cpu_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] ins_in;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [4:0]  imm5;
    logic [15:0] sximm8;
    logic [2:0]  status_in;
    logic [2:0]  status_q;
    logic        done;
    logic        illegal;
    logic        halted;

    int n_vec;
    int n_err;

    cpu_controller #(
        .DATA_W  (16),
        .RADDR_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_in    (ins_in),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .readnum   (readnum),
        .writenum  (writenum),
        .write     (write),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .ALUop     (ALUop),
        .shift     (shift),
        .imm5      (imm5),
        .sximm8    (sximm8),
        .status_in (status_in),
        .status_q  (status_q),
        .done      (done),
        .illegal   (illegal),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] ins);
        ins_in    = ins;
        ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
    endtask

    // Busy cycles = cycles with ins_ready low after the acceptance edge.
    task automatic run_lat(input string tag, input logic [15:0] ins, input int exp);
        int busy;
        accept(ins);
        busy = 0;
        while (ins_ready !== 1'b1 && busy < 20) begin
            busy++;
            step();
        end
        check(tag, busy, exp);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ins_in    = 16'h0000;
        ins_valid = 1'b0;
        status_in = 3'b000;
        #1;
        check("rst_ready", ins_ready, 1);
        check("rst_strobes", {write, loada, loadb, loadc, loads}, 0);
        check("rst_flags", {done, illegal, halted}, 0);
        check("rst_status", status_q, 0);
        #11;
        rst_n = 1'b1;
        step();

        // MOV R0,#-1
        accept(16'hD0FF);
        check("movi_dec_ready", ins_ready, 0);
        check("movi_dec_write", write, 0);
        step();
        check("movi_wb_write", write, 1);
        check("movi_wb_vsel", vsel, 2'b10);
        check("movi_wb_wnum", writenum, 0);
        check("movi_wb_sx8", sximm8, 16'hFFFF);
        check("movi_wb_done", done, 1);
        step();
        check("movi_ready", ins_ready, 1);
        check("movi_done_clr", done, 0);

        // ADD R2,R1,R0
        accept(16'hA140);
        check("add_dec_loada", loada, 0);
        step();
        check("add_geta", {readnum, loada, loadb}, {3'd1, 1'b1, 1'b0});
        step();
        check("add_getb", {readnum, loada, loadb, shift}, {3'd0, 1'b0, 1'b1, 2'b00});
        step();
        check("add_exec", {asel, bsel, ALUop, loadc, loads, done},
              {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
        step();
        check("add_wb", {writenum, write, vsel, done}, {3'd2, 1'b1, 2'b00, 1'b1});
        step();
        check("add_ready", ins_ready, 1);

        // CMP R1,R0
        status_in = 3'b010;
        accept(16'hA900);
        step();
        step();
        step();
        check("cmp_exec", {ALUop, loads, loadc, done, write},
              {2'b01, 1'b1, 1'b0, 1'b1, 1'b0});
        check("cmp_status_pre", status_q, 3'b000);
        step();
        check("cmp_status", status_q, 3'b010);
        check("cmp_nowrite", write, 0);
        status_in = 3'b101;
        step();
        check("cmp_status_hold", status_q, 3'b010);

        // MVN R3,R1 LSL
        accept(16'hB869);
        step();
        check("mvn_getb", {readnum, shift, loadb, loada}, {3'd1, 2'b01, 1'b1, 1'b0});
        step();
        check("mvn_exec", {asel, ALUop, loadc}, {1'b1, 2'b11, 1'b1});
        step();
        check("mvn_wb", {writenum, write, done}, {3'd3, 1'b1, 1'b1});
        step();

        // MOV R3,R1 (register form) execute stage
        accept(16'hC061);
        step();
        step();
        check("movr_exec", {asel, ALUop, loadc}, {1'b1, 2'b00, 1'b1});
        step();
        step();

        run_lat("lat_movi", 16'hD305, 2);
        run_lat("lat_movr", 16'hC061, 4);
        run_lat("lat_mvn", 16'hB869, 4);
        run_lat("lat_cmp", 16'hA900, 4);
        run_lat("lat_add", 16'hA140, 5);
        run_lat("lat_and", 16'hB140, 5);

        // Illegal opcode
        accept(16'h0000);
        check("ill_pulse", illegal, 1);
        check("ill_strobes", {write, loada, loadb, loadc, loads, done}, 0);
        step();
        check("ill_clr", illegal, 0);
        check("ill_ready", ins_ready, 1);

        // HALT is sticky and ignores new instructions
        accept(16'hE000);
        step();
        check("halt_set", halted, 1);
        check("halt_ready", ins_ready, 0);
        ins_in    = 16'hD0FF;
        ins_valid = 1'b1;
        step();
        step();
        check("halt_sticky", {halted, ins_ready, write}, {1'b1, 1'b0, 1'b0});
        ins_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("halt_rst", halted, 0);
        #3;
        rst_n = 1'b1;
        step();

        // Async reset during GET_B of an ADD
        accept(16'hA140);
        step();
        step();
        check("rst_pre_loadb", loadb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strobes", {write, loada, loadb, loadc, loads}, 0);
        check("arst_ready", ins_ready, 1);
        check("arst_status", status_q, 0);
        step();
        #3;
        rst_n = 1'b1;
        step();
        check("arst_post", {ins_ready, write, loadc}, {1'b1, 1'b0, 1'b0});
        step();
        check("arst_post2", {ins_ready, write, done}, {1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
